sha256_sched_ctrl: RTL and testbench



---
 rtl/sha256_sched_ctrl.sv | 161 ++++++++++++++++
 tb/tb_sha256_sched_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_sched_ctrl.sv
// rtl/sha256_sched_ctrl.sv - SHA-256 message-schedule sequencer (W0..W63 from one 16-word block)
//
// Loads one 512-bit block as 16 serial words, then emits the 64-word message
// schedule, one word per w_valid/w_ready handshake.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   flush      synchronous abort back to LOAD, all counts cleared
//   in_valid   input word valid
//   in_ready   block can accept an input word (high in LOAD)
//   in_data    message word, W0 first
//   w_valid    schedule word valid (high in EMIT)
//   w_ready    round engine accepts the word
//   w_data     schedule word Wt
//   w_idx      index t of w_data
//   busy       high in EMIT
//   done       one-cycle pulse after W63 transfers
//   stall_cnt  saturating count of w_valid && !w_ready cycles (SCHED_STALL_CNT_EN only)
//
// Optional feature macro: SCHED_STALL_CNT_EN

module sha256_sched_ctrl #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 64,
  parameter int BLK_WORDS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [WORD_W-1:0] w_data,
  output logic [5:0]        w_idx,
  output logic              busy,
  output logic              done
`ifdef SCHED_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int LCW = $clog2(BLK_WORDS);
  localparam logic [LCW-1:0] LOAD_LAST  = LCW'(BLK_WORDS - 1);
  localparam logic [5:0]     T_LAST     = 6'(NUM_WORDS - 1);
  localparam logic [5:0]     T_FIRST_EX = 6'(BLK_WORDS);

  typedef enum logic {
    LOAD = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [LCW-1:0]     load_cnt_q, load_cnt_d;
  logic [5:0]         t_q, t_d;
  logic               done_q, done_d;
  logic [WORD_W-1:0]  win_q [BLK_WORDS];
  logic [WORD_W-1:0]  win_d [BLK_WORDS];

  logic               in_xfer;
  logic               w_xfer;
  logic [WORD_W-1:0]  expand_word;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Window slot k holds W[t-16+k]: slot 14 = W[t-2], 9 = W[t-7], 1 = W[t-15], 0 = W[t-16].
  assign expand_word = sigma1(win_q[14]) + win_q[9] + sigma0(win_q[1]) + win_q[0];

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    t_d        = t_q;
    done_d     = 1'b0;
    win_d      = win_q;

    in_ready = (state_q == LOAD);
    w_valid  = (state_q == EMIT);
    busy     = (state_q == EMIT);
    w_idx    = t_q;
    done     = done_q;
    w_data   = (t_q < T_FIRST_EX) ? win_q[0] : expand_word;

    in_xfer = in_valid && in_ready;
    w_xfer  = w_valid && w_ready;

    if (flush) begin
      state_d    = LOAD;
      load_cnt_d = '0;
      t_d        = '0;
    end else if (in_xfer) begin
      for (int i = 0; i < BLK_WORDS - 1; i++) win_d[i] = win_q[i+1];
      win_d[BLK_WORDS-1] = in_data;
      if (load_cnt_q == LOAD_LAST) begin
        load_cnt_d = '0;
        t_d        = '0;
        state_d    = EMIT;
      end else begin
        load_cnt_d = load_cnt_q + 1'b1;
      end
    end else if (w_xfer) begin
      // Echo phase re-appends win[0] (a pure rotate) so the window holds
      // W0..W15 again at t=16; expansion phase appends the new word. Both
      // cases push exactly the emitted word.
      for (int i = 0; i < BLK_WORDS - 1; i++) win_d[i] = win_q[i+1];
      win_d[BLK_WORDS-1] = w_data;
      if (t_q == T_LAST) begin
        state_d = LOAD;
        t_d     = '0;
        done_d  = 1'b1;
      end else begin
        t_d = t_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LOAD;
      load_cnt_q <= '0;
      t_q        <= '0;
      done_q     <= 1'b0;
      for (int i = 0; i < BLK_WORDS; i++) win_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      t_q        <= t_d;
      done_q     <= done_d;
      for (int i = 0; i < BLK_WORDS; i++) win_q[i] <= win_d[i];
    end
  end

`ifdef SCHED_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (flush) begin
      stall_q <= '0;
    end else if (w_valid && !w_ready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_sha256_sched_ctrl.sv
// tb/tb_sha256_sched_ctrl.sv - self-checking bench for sha256_sched_ctrl
module tb_sha256_sched_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_data;
  logic [5:0]  w_idx;
  logic        busy;
  logic        done;
`ifdef SCHED_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  sha256_sched_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .w_valid  (w_valid),
    .w_ready  (w_ready),
    .w_data   (w_data),
    .w_idx    (w_idx),
    .busy     (busy),
    .done     (done)
`ifdef SCHED_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  logic [31:0] blk   [16];
  logic [31:0] exp_w [64];
  logic [31:0] got   [64];

  typedef struct {
    int          idx;
    logic [31:0] exp;
  } kat_t;
  kat_t kat [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  // Reference schedule straight from the recurrence on a plain array.
  task automatic build_model();
    for (int t = 0; t < 64; t++) begin
      if (t < 16) exp_w[t] = blk[t];
      else exp_w[t] = (rr(exp_w[t-2], 17) ^ rr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10))
                      + exp_w[t-7]
                      + (rr(exp_w[t-15], 7) ^ rr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3))
                      + exp_w[t-16];
    end
  endtask

  task automatic compare_model(input string tag);
    for (int t = 0; t < 64; t++) check($sformatf("%s_W%0d", tag, t), got[t], exp_w[t]);
  endtask

  // Called at a negedge; returns at the negedge after the 16th transfer.
  task automatic load_block(output int cycles);
    int k = 0;
    cycles = 0;
    while (k < 16 && cycles < 200) begin
      in_valid = 1'b1;
      in_data  = blk[k];
      if (in_ready) k++;
      @(negedge clk);
      cycles++;
    end
    in_valid = 1'b0;
    if (k < 16) check("load_timeout", k, 16);
  endtask

  // mode 0: always ready, 1: 1-on/2-off, 2: random. Returns at the negedge
  // after the 64th transfer, where done must be high.
  task automatic collect(input int mode, output int n);
    int          cyc = 0;
    logic        stalled = 1'b0;
    logic [31:0] pd = '0;
    logic [5:0]  pi = '0;
    n = 0;
    while (n < 64 && cyc < 2000) begin
      if (w_valid) begin
        if (stalled) begin
          check("stall_data_stable", w_data, pd);
          check("stall_idx_stable", {26'd0, w_idx}, {26'd0, pi});
        end
        case (mode)
          0:       w_ready = 1'b1;
          1:       w_ready = (cyc % 3 == 0);
          default: w_ready = 1'($urandom_range(0, 1));
        endcase
        if (w_ready) begin
          got[n] = w_data;
          check("w_idx", {26'd0, w_idx}, n);
          n++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          pd = w_data;
          pi = w_idx;
        end
      end else begin
        w_ready = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    w_ready = 1'b0;
    check("xfer_count", n, 64);
    check("done_pulse", done, 1'b1);
    check("after_emit_in_ready", in_ready, 1'b1);
    check("after_emit_busy", busy, 1'b0);
  endtask

  initial begin
    int n;
    int cyc;
    int g;
    kat[0] = '{0,  32'h61626380};
    kat[1] = '{1,  32'h00000000};
    kat[2] = '{14, 32'h00000000};
    kat[3] = '{15, 32'h00000018};
    kat[4] = '{16, 32'h61626380};
    kat[5] = '{17, 32'h000F0000};
    kat[6] = '{18, 32'h7DA86405};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; w_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_w_valid", w_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_w_idx", {26'd0, w_idx}, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_in_ready", in_ready, 1'b1);
    check("idle_w_valid", w_valid, 1'b0);
    check("idle_w_idx", {26'd0, w_idx}, 0);

    // "abc" block, full throughput
    for (int i = 0; i < 16; i++) blk[i] = '0;
    blk[0] = 32'h61626380;
    blk[15] = 32'h00000018;
    build_model();
    load_block(cyc);
    check("abc_load_cycles", cyc, 16);
    check("abc_first_w_valid", w_valid, 1'b1);
    check("abc_busy", busy, 1'b1);
    collect(0, n);
    for (int i = 0; i < 7; i++) check($sformatf("abc_kat_W%0d", kat[i].idx), got[kat[i].idx], kat[i].exp);
    compare_model("abc");
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);

    // backpressure 1-on/2-off
    load_block(cyc);
    collect(1, n);
    compare_model("bp");
    @(negedge clk);

    // flush mid-EMIT at w_idx 30
    load_block(cyc);
    g = 0;
    while (!(w_valid && w_idx == 6'd30) && g < 100) begin
      w_ready = 1'b1;
      @(negedge clk);
      g++;
    end
    check("reach_idx30", {26'd0, w_idx}, 30);
    flush = 1'b1;
    w_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    w_ready = 1'b0;
    check("flush_in_ready", in_ready, 1'b1);
    check("flush_w_valid", w_valid, 1'b0);
    check("flush_w_idx", {26'd0, w_idx}, 0);
    check("flush_done", done, 1'b0);
    for (int i = 0; i < 16; i++) blk[i] = 32'(i + 1);
    build_model();
    load_block(cyc);
    collect(0, n);
    check("post_flush_W0", got[0], 32'h00000001);
    compare_model("postflush");

    // back-to-back: next block's first word presented while done is high
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
    build_model();
    load_block(cyc);
    @(negedge clk);
    collect(0, n);
    compare_model("b2b_a");
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
    build_model();
    check("b2b_in_ready_at_done", in_ready, 1'b1);
    load_block(cyc);
    check("b2b_load_cycles", cyc, 16);
    check("b2b_w_valid", w_valid, 1'b1);
    collect(0, n);
    compare_model("b2b_b");
    @(negedge clk);

    // random blocks with random backpressure
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 16; i++) blk[i] = $urandom;
      build_model();
      load_block(cyc);
      collect(2, n);
      compare_model($sformatf("rnd%0d", b));
      @(negedge clk);
    end

    // flush mid-LOAD: partial words discarded, count restarts
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = $urandom; @(negedge clk);
    end
    in_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    check("load_flush_w_valid", w_valid, 1'b0);
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
    build_model();
    load_block(cyc);
    check("load_flush_cycles", cyc, 16);
    collect(0, n);
    compare_model("loadflush");
    @(negedge clk);

    // asynchronous reset mid-EMIT
    load_block(cyc);
    w_ready = 1'b1;
    repeat (5) @(negedge clk);
    w_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_in_ready", in_ready, 1'b1);
    check("async_rst_w_valid", w_valid, 1'b0);
    check("async_rst_w_idx", {26'd0, w_idx}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", busy, 1'b0);

`ifdef SCHED_STALL_CNT_EN
    check("stall_after_rst", stall_cnt, 16'd0);
    load_block(cyc);
    w_ready = 1'b0;
    repeat (100) @(negedge clk);
    check("stall_cnt_100", stall_cnt, 16'd100);
    check("stall_w_idx", {26'd0, w_idx}, 0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("stall_cnt_flush", stall_cnt, 16'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
